// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg -- shared types and constants for the framed UART receiver.
//   fetch_state_e : bus fetch sequencer states (poll status, read byte, emit).
//   parse_state_e : frame parser states (hunt SOF, length, payload, check).
//   *_BIT         : bit positions inside the buffered-UART status word.
//   SOF_DEFAULT   : default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    F_POLL,
    F_WAIT_STATUS,
    F_READ,
    F_WAIT_BYTE,
    F_EMIT
  } fetch_state_e;

  typedef enum logic [1:0] {
    P_HUNT,
    P_LEN,
    P_PAYLOAD,
    P_CHECK
  } parse_state_e;

  localparam int unsigned RX_EMPTY_BIT = 3;
  localparam int unsigned RX_FULL_BIT  = 2;
  localparam int unsigned TX_EMPTY_BIT = 1;
  localparam int unsigned TX_FULL_BIT  = 0;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// frame_buf -- DEPTH x WIDTH payload buffer, one write port, one async read port.
//   clock            : rising-edge clock
//   wr_en/addr/data  : synchronous write port
//   rd_addr/rd_data  : combinational read port
// Contents are not reset; only indices below the committed length are ever read.
module frame_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx -- polls a buffered UART over a simple read bus, parses
// SOF / LEN / payload [/ CHECK] frames and streams accepted payloads out.
//   clock, resetn        : rising-edge clock, synchronous active-low reset
//   bus_addr, bus_rd_en  : one-cycle read strobe to the UART (status or RX FIFO)
//   bus_rdata            : UART read data, valid the cycle after a strobe
//   m_data/m_valid/m_ready/m_last : payload stream
//   frame_ok, frame_err  : one-cycle pulses on frame accept / discard
// Build option: define UART_FRAME_CHECKSUM_EN to require a trailing XOR check
// byte (covering LEN and payload); otherwise a frame commits on its last
// payload byte.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      ADDRESS_WIDTH  = 4,
  parameter int unsigned      RX_ADDRESS     = 1,
  parameter int unsigned      STATUS_ADDRESS = 2,
  parameter int unsigned      MAX_PAYLOAD    = 16,
  parameter logic [WIDTH-1:0] SOF            = WIDTH'(SOF_DEFAULT)
) (
  input  logic                     clock,
  input  logic                     resetn,
  output logic [ADDRESS_WIDTH-1:0] bus_addr,
  output logic                     bus_rd_en,
  input  logic [WIDTH-1:0]         bus_rdata,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     frame_ok,
  output logic                     frame_err
);

  localparam int unsigned IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [WIDTH-1:0]         MAX_LEN  = WIDTH'(MAX_PAYLOAD);
  localparam logic [ADDRESS_WIDTH-1:0] STATUS_A = ADDRESS_WIDTH'(STATUS_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] RX_A     = ADDRESS_WIDTH'(RX_ADDRESS);

  fetch_state_e fetch_q, fetch_d;
  parse_state_e parse_q, parse_d;

  logic [WIDTH-1:0]         len_q, len_d;
  logic [WIDTH-1:0]         xor_q, xor_d;
  // Payload write index while parsing, reused as the read index while emitting.
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                     bus_rd_en_q, bus_rd_en_d;
  logic                     frame_ok_q, frame_ok_d;
  logic                     frame_err_q, frame_err_d;

  logic                     commit;
  logic                     last_idx;
  logic                     buf_wr_en;
  logic [WIDTH-1:0]         buf_rd_data;

  frame_buf #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_PAYLOAD)
  ) u_frame_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (cnt_q),
    .wr_data (bus_rdata),
    .rd_addr (cnt_q),
    .rd_data (buf_rd_data)
  );

  assign last_idx = (WIDTH'(cnt_q) == (len_q - WIDTH'(1)));

  always_comb begin
    fetch_d     = fetch_q;
    parse_d     = parse_q;
    len_d       = len_q;
    xor_d       = xor_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_rd_en_d = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    buf_wr_en   = 1'b0;
    commit      = 1'b0;

    case (fetch_q)
      // The strobe is registered, so it is issued on entry to POLL. Straight
      // out of reset no strobe has been issued yet, so POLL waits one cycle.
      F_POLL: begin
        if (bus_rd_en_q) begin
          fetch_d = F_WAIT_STATUS;
        end
      end
      F_WAIT_STATUS: begin
        fetch_d = bus_rdata[RX_EMPTY_BIT] ? F_POLL : F_READ;
      end
      F_READ: begin
        fetch_d = F_WAIT_BYTE;
      end
      F_WAIT_BYTE: begin
        fetch_d = F_POLL;
        case (parse_q)
          P_HUNT: begin
            if (bus_rdata == SOF) begin
              parse_d = P_LEN;
            end
          end
          P_LEN: begin
            if ((bus_rdata == '0) || (bus_rdata > MAX_LEN)) begin
              frame_err_d = 1'b1;
              parse_d     = P_HUNT;
            end else begin
              len_d   = bus_rdata;
              xor_d   = bus_rdata;
              cnt_d   = '0;
              parse_d = P_PAYLOAD;
            end
          end
          P_PAYLOAD: begin
            buf_wr_en = 1'b1;
            xor_d     = xor_q ^ bus_rdata;
            if (last_idx) begin
              cnt_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
              parse_d = P_CHECK;
`else
              parse_d = P_HUNT;
              commit  = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + IDX_W'(1);
            end
          end
`ifdef UART_FRAME_CHECKSUM_EN
          P_CHECK: begin
            parse_d = P_HUNT;
            if (bus_rdata == xor_q) begin
              commit = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
`endif
          default: parse_d = P_HUNT;
        endcase
        if (commit) begin
          frame_ok_d = 1'b1;
          fetch_d    = F_EMIT;
        end
      end
      F_EMIT: begin
        if (m_ready) begin
          if (last_idx) begin
            cnt_d   = '0;
            fetch_d = F_POLL;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      default: fetch_d = F_POLL;
    endcase

    // Strobe and address follow the state being entered so they are
    // registered and line up with the POLL / READ cycle itself.
    if (fetch_d == F_POLL) begin
      bus_rd_en_d = 1'b1;
      bus_addr_d  = STATUS_A;
    end else if (fetch_d == F_READ) begin
      bus_rd_en_d = 1'b1;
      bus_addr_d  = RX_A;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      fetch_q     <= F_POLL;
      parse_q     <= P_HUNT;
      len_q       <= '0;
      xor_q       <= '0;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_rd_en_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      fetch_q     <= fetch_d;
      parse_q     <= parse_d;
      len_q       <= len_d;
      xor_q       <= xor_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_rd_en_q <= bus_rd_en_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_rd_en = bus_rd_en_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign m_valid   = (fetch_q == F_EMIT);
  assign m_data    = m_valid ? buf_rd_data : '0;
  assign m_last    = m_valid && last_idx;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx -- self-checking bench for uart_frame_rx.
// A behavioural buffered-UART answers the bus; a stream-level reference model
// derives the expected payloads and frame_ok / frame_err counts from each byte
// sequence fed to the UART FIFO.
module tb_uart_frame_rx;

  localparam int unsigned AW   = 4;
  localparam int          RX_A = 1;
  localparam int          ST_A = 2;
  localparam int          MAXP = 16;
  localparam logic [7:0]  SOF_B = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];

  logic          clock = 1'b0;
  logic          resetn;
  logic [AW-1:0] bus_addr;
  logic          bus_rd_en;
  logic [7:0]    bus_rdata;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          frame_ok;
  logic          frame_err;

  uart_frame_rx #(
    .WIDTH          (8),
    .ADDRESS_WIDTH  (AW),
    .RX_ADDRESS     (RX_A),
    .STATUS_ADDRESS (ST_A),
    .MAX_PAYLOAD    (MAXP),
    .SOF            (SOF_B)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus_addr  (bus_addr),
    .bus_rd_en (bus_rd_en),
    .bus_rdata (bus_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  bq_t  rx_q;
  bq_t  exp_q;
  logic exp_last_q [$];
  bq_t  build_q;
  bq_t  pl_q;

  int checks = 0, failures = 0;
  int exp_ok = 0, exp_err = 0, got_ok = 0, got_err = 0, hs_cnt = 0;
  int ready_mode = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Stream-level reference: scan for SOF, validate length, gather payload,
  // verify the optional XOR check, and record what must come out.
  task automatic ref_model(input bq_t s);
    int n, i, len;
    logic [7:0] x;
    bq_t pl;
    n = s.size();
    i = 0;
    while (i < n) begin
      if (s[i] != SOF_B) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) break;
      len = int'(s[i]);
      i++;
      if (len == 0 || len > MAXP) begin
        exp_err++;
        continue;
      end
      if (i + len + (CSUM ? 1 : 0) > n) break;
      x = 8'(len);
      pl.delete();
      for (int k = 0; k < len; k++) begin
        pl.push_back(s[i + k]);
        x = x ^ s[i + k];
      end
      i += len;
      if (CSUM) begin
        if (s[i] != x) begin
          exp_err++;
          i++;
          continue;
        end
        i++;
      end
      exp_ok++;
      for (int k = 0; k < len; k++) begin
        exp_q.push_back(pl[k]);
        exp_last_q.push_back(k == len - 1);
      end
    end
  endtask

  task automatic send(input bq_t s);
    ref_model(s);
    foreach (s[k]) rx_q.push_back(s[k]);
  endtask

  // Appends SOF, LEN, pl_q and (when enabled) a check byte to build_q.
  task automatic add_frame(input logic bad_chk);
    logic [7:0] x;
    x = 8'(pl_q.size());
    build_q.push_back(SOF_B);
    build_q.push_back(8'(pl_q.size()));
    foreach (pl_q[k]) begin
      build_q.push_back(pl_q[k]);
      x = x ^ pl_q[k];
    end
    if (CSUM) build_q.push_back(bad_chk ? ~x : x);
  endtask

  task automatic rand_payload(input int len);
    logic [7:0] b;
    pl_q.delete();
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = SOF_B;
      pl_q.push_back(b);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_addr"},  32'(bus_addr), 0);
    check_eq({tag, "_rd_en"}, 32'(bus_rd_en), 0);
    check_eq({tag, "_data"},  32'(m_data), 0);
    check_eq({tag, "_valid"}, 32'(m_valid), 0);
    check_eq({tag, "_last"},  32'(m_last), 0);
    check_eq({tag, "_ok"},    32'(frame_ok), 0);
    check_eq({tag, "_err"},   32'(frame_err), 0);
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done  = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clock);
      if (rx_q.size() == 0 && exp_q.size() == 0 && !m_valid) quiet++;
      else quiet = 0;
      if (quiet >= 8) done = 1'b1;
    end
    check_eq({tag, "_idle"}, 32'(done), 1);
    check_eq({tag, "_ok_cnt"}, 32'(got_ok), 32'(exp_ok));
    check_eq({tag, "_err_cnt"}, 32'(got_err), 32'(exp_err));
  endtask

  task automatic wait_handshake(input string tag, input int base);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clock);
      if (hs_cnt > base) seen = 1'b1;
    end
    check_eq({tag, "_hs_seen"}, 32'(seen), 1);
  endtask

  // Buffered UART: answers a strobe one cycle later, garbage otherwise.
  initial begin : uart_model
    logic pend;
    logic [AW-1:0] pend_addr;
    logic [7:0] st;
    pend = 1'b0;
    pend_addr = '0;
    bus_rdata = '0;
    forever begin
      @(negedge clock);
      if (pend && int'(pend_addr) == ST_A) begin
        st = 8'($urandom);
        st[3] = (rx_q.size() == 0);
        bus_rdata = st;
      end else if (pend && int'(pend_addr) == RX_A && rx_q.size() != 0) begin
        bus_rdata = rx_q.pop_front();
      end else begin
        bus_rdata = 8'($urandom);
      end
      pend = bus_rd_en;
      pend_addr = bus_addr;
    end
  end

  initial begin : ready_drv
    m_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    logic stalled;
    logic [7:0] pdata;
    logic plast;
    stalled = 1'b0;
    pdata = '0;
    plast = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        stalled = 1'b0;
      end else begin
        if (frame_ok) got_ok++;
        if (frame_err) got_err++;
        if (stalled) begin
          check_eq("hold_valid", 32'(m_valid), 1);
          check_eq("hold_data", 32'(m_data), 32'(pdata));
          check_eq("hold_last", 32'(m_last), 32'(plast));
        end
        if (m_valid) check_eq("no_bus_in_emit", 32'(bus_rd_en), 0);
        if (bus_rd_en && int'(bus_addr) != ST_A && int'(bus_addr) != RX_A)
          check_eq("bus_addr", 32'(bus_addr), 32'(ST_A));
        if (m_valid && m_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check_eq("extra_byte", 32'(exp_q.size()), 1);
          end else begin
            check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            check_eq("m_last", 32'(m_last), 32'(exp_last_q.pop_front()));
          end
        end
        stalled = m_valid && !m_ready;
        pdata = m_data;
        plast = m_last;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : main
    int ok0, err0, base, r, len;
    logic [7:0] b, held;

    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("rst");
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check_eq("rel_rd_en", 32'(bus_rd_en), 0);

    // Empty FIFO: strobes alternate and only ever target the status word.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq("poll_en", 32'(bus_rd_en), 32'(i % 2 == 0));
      if (bus_rd_en) check_eq("poll_addr", 32'(bus_addr), 32'(ST_A));
    end

    ready_mode = 2;

    // Two-byte frame 11 22.
    ok0 = got_ok;
    build_q.delete();
    pl_q = '{8'h11, 8'h22};
    add_frame(1'b0);
    send(build_q);
    wait_idle("f1122");
    check_eq("f1122_frames", 32'(got_ok - ok0), 1);

`ifdef UART_FRAME_CHECKSUM_EN
    // Bad check byte, then a good frame.
    ok0 = got_ok;
    err0 = got_err;
    build_q = '{SOF_B, 8'h02, 8'h11, 8'h22, 8'h30};
    pl_q = '{8'h33};
    add_frame(1'b0);
    send(build_q);
    wait_idle("badchk");
    check_eq("badchk_err", 32'(got_err - err0), 1);
    check_eq("badchk_ok", 32'(got_ok - ok0), 1);
`endif

    // Length 0 and length MAX+1 both rejected.
    ok0 = got_ok;
    err0 = got_err;
    build_q = '{8'h00, SOF_B, 8'h00, SOF_B, 8'h11, 8'h00};
    send(build_q);
    wait_idle("badlen");
    check_eq("badlen_err", 32'(got_err - err0), 2);
    check_eq("badlen_ok", 32'(got_ok - ok0), 0);

    // Maximum-length frame followed by a one-byte frame.
    build_q.delete();
    rand_payload(MAXP);
    add_frame(1'b0);
    rand_payload(1);
    add_frame(1'b0);
    send(build_q);
    wait_idle("maxlen");

    // Backpressure for 20 cycles after the first payload byte.
    base = hs_cnt;
    build_q.delete();
    rand_payload(6);
    add_frame(1'b0);
    send(build_q);
    wait_handshake("bp", base);
    #1 ready_mode = 1;
    @(negedge clock);
    held = m_data;
    check_eq("bp_second_byte", 32'(m_data), 32'(pl_q[1]));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq("bp_valid", 32'(m_valid), 1);
      check_eq("bp_data", 32'(m_data), 32'(held));
      check_eq("bp_rd_en", 32'(bus_rd_en), 0);
    end
    ready_mode = 0;
    wait_idle("bp");

    // Reset while the second EMIT byte is presented.
    ready_mode = 2;
    base = hs_cnt;
    build_q.delete();
    rand_payload(3);
    add_frame(1'b0);
    send(build_q);
    wait_handshake("emrst", base);
    #1;
    ready_mode = 1;
    resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    exp_q.delete();
    exp_last_q.delete();
    @(negedge clock);
    check_zero("emrst");
    @(negedge clock);
    check_eq("emrst_poll_en", 32'(bus_rd_en), 1);
    check_eq("emrst_poll_addr", 32'(bus_addr), 32'(ST_A));
    ready_mode = 0;
    wait_idle("emrst");

    // Random mix of garbage, bad lengths, good and bad-check frames.
    for (int sec = 0; sec < 3; sec++) begin
      build_q.delete();
      for (int u = 0; u < 15; u++) begin
        r = $urandom_range(0, 5);
        case (r)
          0: begin
            b = 8'($urandom);
            if (b == SOF_B) b = 8'h00;
            build_q.push_back(b);
          end
          1: begin
            build_q.push_back(SOF_B);
            if ($urandom_range(0, 1) == 0) build_q.push_back(8'h00);
            else build_q.push_back(8'($urandom_range(MAXP + 1, 255)));
          end
          5: begin
            len = $urandom_range(1, MAXP);
            rand_payload(len);
            add_frame(1'b1);
          end
          default: begin
            len = $urandom_range(1, MAXP);
            rand_payload(len);
            add_frame(1'b0);
          end
        endcase
      end
      send(build_q);
      wait_idle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
